// File: rtl/carry_save_resolver_if.sv
// Row-pair in / resolved value out bundle between the compressor tree and the resolver.
// Latency: none (wires only).
// Backpressure: valid/ready on both the input row pair and the resolved output.
// Ports: in_valid/in_ready/in_sum/in_carry (row pair), out_valid/out_ready/out_value (result).
// master = producer/consumer side, slave = resolver side.
interface carry_save_resolver_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH+1:0] out_value;

  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_value
  );

  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_value
  );
endinterface

// File: rtl/carry_save_resolver.sv
// Resolves a redundant (sum, carry) row pair into binary: sum + (carry << 1).
// Latency: out_valid rises NCHUNK edges after the accepting edge (CHUNK bits per clock).
// Backpressure: accepts only in IDLE; result is held in DONE until out_ready.
// Ports: clk, rst_n (async active-low), bus (slave side of carry_save_resolver_if),
//        busy (high while a row pair is being resolved or its result is pending).
module carry_save_resolver #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  carry_save_resolver_if.slave bus,
  output logic                 busy
);

  localparam int OW     = WIDTH + 2;
  localparam int NCHUNK = (OW + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   opa;
  logic [PW-1:0]   opb;
  logic [PW-1:0]   res;
  logic [PW-1:0]   res_nxt;
  logic [IW-1:0]   idx;
  logic            c;
  logic [CHUNK:0]  chunk_sum;
  logic            last_chunk;
  logic            accept;
  logic [OW-1:0]   out_value_q;

  assign accept     = (state == IDLE) && bus.in_valid;
  assign last_chunk = (idx == LAST_IDX);

  // One CHUNK-wide ripple slice per clock; the slice result is merged into
  // the working result so the finished value can be latched in one shot.
  always_comb begin
    chunk_sum = {1'b0, opa[int'(idx)*CHUNK +: CHUNK]}
              + {1'b0, opb[int'(idx)*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, c};
    res_nxt = res;
    res_nxt[int'(idx)*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; in_valid is deliberately ignored outside IDLE so a
  // held input is taken only on the IDLE edge after the output handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last_chunk)    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    busy          = (state != IDLE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa         <= '0;
      opb         <= '0;
      res         <= '0;
      idx         <= '0;
      c           <= 1'b0;
      out_value_q <= '0;
    end else if (accept) begin
      // Operands are zero-padded to a whole number of chunks; the carry row
      // is pre-shifted to its true weight.
      opa <= PW'(bus.in_sum);
      opb <= PW'({bus.in_carry, 1'b0});
      res <= '0;
      idx <= '0;
      c   <= 1'b0;
    end else if (state == RUN) begin
      res <= res_nxt;
      c   <= chunk_sum[CHUNK];
      idx <= idx + 1'b1;
      // out_value only changes when a complete result exists, so it keeps
      // the previous result through the next RUN.
      if (last_chunk) begin
        out_value_q <= res_nxt[OW-1:0];
      end
    end
  end

  assign bus.out_value = out_value_q;

  // OW bits always hold 3*(2^WIDTH-1), so the last slice cannot carry out.
  a_final_carry_zero : assert property (
    @(posedge clk) disable iff (!rst_n)
    (state == RUN && last_chunk) |-> !chunk_sum[CHUNK]
  );

endmodule

// File: tb/tb_carry_save_resolver.sv
module tb_carry_save_resolver;

  localparam int W  = 16;
  localparam int OW = W + 2;
  localparam int NL = 3;
  localparam int NRAND = 1500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NL-1:0]         in_valid;
  logic [NL-1:0]         in_ready;
  logic [NL-1:0]         out_valid;
  logic [NL-1:0]         out_ready;
  logic [NL-1:0]         busy;
  logic [NL-1:0][W-1:0]  in_sum;
  logic [NL-1:0][W-1:0]  in_carry;
  logic [NL-1:0][OW-1:0] out_value;

  int checks = 0;
  int errors = 0;

  // Lane 0: CHUNK=1, lane 1: CHUNK=4, lane 2: CHUNK=18 (single RUN cycle)
  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int CH = (g == 0) ? 1 : ((g == 1) ? 4 : 18);
    carry_save_resolver_if #(.WIDTH(W)) bus ();
    assign bus.in_valid  = in_valid[g];
    assign bus.in_sum    = in_sum[g];
    assign bus.in_carry  = in_carry[g];
    assign bus.out_ready = out_ready[g];
    assign in_ready[g]   = bus.in_ready;
    assign out_valid[g]  = bus.out_valid;
    assign out_value[g]  = bus.out_value;
    carry_save_resolver #(.WIDTH(W), .CHUNK(CH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .busy  (busy[g])
    );
  end

  function automatic int chunk_of(int l);
    return (l == 0) ? 1 : ((l == 1) ? 4 : 18);
  endfunction

  function automatic int nchunk(int l);
    return (OW + chunk_of(l) - 1) / chunk_of(l);
  endfunction

  // Reference: plain integer arithmetic of the redundant pair.
  function automatic logic [OW-1:0] model(logic [W-1:0] s, logic [W-1:0] cy);
    int unsigned v;
    v = int'(s) + 2 * int'(cy);
    return v[OW-1:0];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(int l, logic [W-1:0] s, logic [W-1:0] cy, bit hold);
    int n;
    in_valid[l] = 1'b1;
    in_sum[l]   = s;
    in_carry[l] = cy;
    n = 0;
    while (!in_ready[l] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("accept_ready_l%0d", l), 32'(in_ready[l]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) in_valid[l] = 1'b0;
    chk($sformatf("ready_low_after_accept_l%0d", l), 32'(in_ready[l]), 32'd0);
  endtask

  // Waits for out_valid, checks latency and value; completes the handshake if out_ready.
  task automatic get(int l, logic [OW-1:0] exp, string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid[l] && lat < 64);
    chk($sformatf("%s_latency_l%0d", tag, l), 32'(lat), 32'(nchunk(l)));
    chk($sformatf("%s_value_l%0d", tag, l), 32'(out_value[l]), 32'(exp));
    chk($sformatf("%s_ready_in_done_l%0d", tag, l), 32'(in_ready[l]), 32'd0);
    if (out_ready[l]) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s_valid_drop_l%0d", tag, l), 32'(out_valid[l]), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] s, cy, s2, cy2;
    logic [W-1:0] bs [4];
    logic [W-1:0] bc [4];
    int r;

    in_valid  = '0;
    in_sum    = '0;
    in_carry  = '0;
    out_ready = '1;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("rst_in_ready_l%0d", l), 32'(in_ready[l]), 32'd1);
      chk($sformatf("rst_out_valid_l%0d", l), 32'(out_valid[l]), 32'd0);
      chk($sformatf("rst_out_value_l%0d", l), 32'(out_value[l]), 32'd0);
      chk($sformatf("rst_busy_l%0d", l), 32'(busy[l]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // 1: smallest non-trivial pair
    send(1, 16'h0001, 16'h0001, 1'b0);
    get(1, 18'h00003, "t1");
    chk("t1_const", 32'(out_value[1]), 32'h00003);

    // 2: all ones, exercises the widest carry chain
    send(1, 16'hFFFF, 16'hFFFF, 1'b0);
    get(1, 18'h2FFFD, "t2");
    chk("t2_const", 32'(out_value[1]), 32'h2FFFD);

    // 3: backpressure in DONE with a new input already waiting
    s = 16'h1234; cy = 16'h0F0F;
    s2 = 16'hA5A5; cy2 = 16'h5A5A;
    out_ready[1] = 1'b0;
    send(1, s, cy, 1'b0);
    get(1, model(s, cy), "t3");
    in_valid[1] = 1'b1;
    in_sum[1]   = s2;
    in_carry[1] = cy2;
    repeat (10) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(out_valid[1]), 32'd1);
      chk("t3_hold_ready", 32'(in_ready[1]), 32'd0);
      chk("t3_hold_value", 32'(out_value[1]), 32'(model(s, cy)));
      chk("t3_hold_busy", 32'(busy[1]), 32'd1);
    end
    out_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t3_release_valid", 32'(out_valid[1]), 32'd0);
    chk("t3_release_ready", 32'(in_ready[1]), 32'd1);
    send(1, s2, cy2, 1'b0);
    get(1, model(s2, cy2), "t3b");

    // 4: asynchronous reset while idx=2
    send(1, 16'h7777, 16'h1111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_valid", 32'(out_valid[1]), 32'd0);
    chk("t4_async_value", 32'(out_value[1]), 32'd0);
    chk("t4_async_busy", 32'(busy[1]), 32'd0);
    chk("t4_async_ready", 32'(in_ready[1]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("t4_no_pulse", 32'(out_valid[1]), 32'd0);
    end
    send(1, 16'hBEEF, 16'h0123, 1'b0);
    get(1, model(16'hBEEF, 16'h0123), "t4");

    // 5: back-to-back, in_valid held high, out_ready=1
    for (int k = 0; k < 4; k++) begin
      bs[k] = 16'($urandom);
      bc[k] = 16'($urandom);
    end
    for (int k = 0; k < 4; k++) begin
      send(1, bs[k], bc[k], 1'b1);
      get(1, model(bs[k], bc[k]), $sformatf("t5_%0d", k));
    end
    in_valid[1] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t5_idle_no_dup", 32'(out_valid[1]), 32'd0);
    end

    // 6: random pairs on every CHUNK variant
    for (int i = 0; i < NRAND; i++) begin
      for (int l = 0; l < NL; l++) begin
        r = $urandom_range(0, 7);
        if (r == 0) begin
          s = '1; cy = '1;
        end else if (r == 1) begin
          s = '0; cy = 16'($urandom);
        end else begin
          s = 16'($urandom); cy = 16'($urandom);
        end
        send(l, s, cy, 1'b0);
        get(l, model(s, cy), "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
